// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider control for the EX stage: one quotient bit per cycle.
// Signed DIV support is compiled in only when DIV_SIGNED_EN is defined.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] divisor;
    logic [63:0] work;          // {partial remainder, dividend bits / quotient bits}
    logic [32:0] diff;
    logic [63:0] work_next;
    logic        go;
    logic [31:0] mag1, mag2;
    logic [31:0] final_q, final_r;

    assign go = start_i & ~annul_i;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    always_comb begin
        mag1    = (signed_div_i & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2    = (signed_div_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        final_q = neg_q ? (~work_next[31:0] + 32'd1) : work_next[31:0];
        final_r = neg_r ? (~work_next[63:32] + 32'd1) : work_next[63:32];
    end
`else
    logic unused_signed;
    assign unused_signed = signed_div_i;

    always_comb begin
        mag1    = opdata1_i;
        mag2    = opdata2_i;
        final_q = work_next[31:0];
        final_r = work_next[63:32];
    end
`endif

    // Trial subtraction on the top 33 bits; quotient bits shift in as dividend bits shift out.
    always_comb begin
        diff = work[63:31] - {1'b0, divisor};
        if (diff[32])
            work_next = {work[62:0], 1'b0};
        else
            work_next = {diff[31:0], work[30:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    stall_o    = 1'b1;
                    state_next = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                stall_o    = 1'b1;
                state_next = go ? S_END : S_IDLE;
            end
            S_ON: begin
                stall_o = 1'b1;
                if (!go)
                    state_next = S_IDLE;
                else if (cnt == 5'd31)
                    state_next = S_END;
            end
            S_END: begin
                if (!go)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (rst)
            stall_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            divisor  <= '0;
            work     <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            ready_o <= (state_next == S_END);
            case (state)
                S_IDLE: begin
                    if (go) begin
                        divisor <= mag2;
                        work    <= {32'd0, mag1};
                        cnt     <= '0;
`ifdef DIV_SIGNED_EN
                        neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i & opdata1_i[31];
`endif
                    end
                end
                S_ON: begin
                    work <= work_next;
                    cnt  <= cnt + 5'd1;
                end
                default: ;
            endcase
            // Result is only loaded on entry to END and held while in END; zero elsewhere.
            if (state_next != S_END || state == S_BYZERO)
                result_o <= '0;
            else if (state == S_ON)
                result_o <= {final_r, final_q};
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver pushes expected results from an arithmetic
// model, a negedge monitor pops and compares whenever ready_o rises.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] res;
        int unsigned drive_cyc;
        int unsigned lat;
    } exp_t;

    exp_t sb_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer division; signed uses 64-bit math, truncated to 32 bits.
    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic sgn);
        logic        use_signed;
        longint      sa, sb, sq, sr;
        logic [63:0] vq, vr;
        use_signed = sgn;
`ifndef DIV_SIGNED_EN
        use_signed = 1'b0;
`endif
        if (b == 32'd0)
            return 64'd0;
        if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            vq = sq;
            vr = sr;
            return {vr[31:0], vq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Latency counts the accept edge as the first edge.
    always @(negedge clk) begin : monitor
        static logic ready_prev = 1'b0;
        exp_t item;
        if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                item = sb_q.pop_front();
                check("sb_result", result_o, item.res);
                check("sb_latency", 64'(cyc - item.drive_cyc), 64'(item.lat));
            end
        end
        ready_prev = ready_o;
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        exp_t e;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        e.res        = model(a, b, sgn);
        e.drive_cyc  = cyc;
        e.lat        = (b == 32'd0) ? 2 : 33;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(output int unsigned stalls);
        bit seen;
        seen   = 1'b0;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall_o === 1'b1) stalls++;
            @(negedge clk);
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_end(input int unsigned hold, input logic [63:0] exp_res);
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            #1;
            check("end_hold_ready", 64'(ready_o), 64'd1);
            check("end_hold_result", result_o, exp_res);
            check("end_hold_stall", 64'(stall_o), 64'd0);
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("release_ready", 64'(ready_o), 64'd0);
        check("release_result", result_o, 64'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int unsigned hold, output logic [63:0] got);
        int unsigned st;
        @(negedge clk);
        launch(a, b, sgn);
        wait_ready(st);
        got = result_o;
        check("stall_cycles", 64'(st), (b == 32'd0) ? 64'd2 : 64'd33);
        release_end(hold, model(a, b, sgn));
    endtask

    initial begin
        logic [63:0]  got;
        int unsigned  st;
        logic [31:0]  ra, rb;

        rst          = 1'b1;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        start_i = 1'b0;
        rst     = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, got);
        check("u100_7", got, 64'h00000002_0000000E);

        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, got);
`ifdef DIV_SIGNED_EN
        check("s_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);
`else
        check("s_m7_2", got, 64'h00000001_7FFFFFFC);
`endif

        run_div(32'd5, 32'd0, 1'b0, 0, got);
        check("div_by_zero", got, 64'd0);

        // Annul in ON cycle 10
        @(negedge clk);
        launch(32'd123456789, 32'd1000, 1'b0);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        #1;
        check("annul_idle_stall", 64'(stall_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        void'(sb_q.pop_back());
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, got);
        check("u_ffffffff_1", got, 64'h00000000_FFFFFFFF);

        // Reset in ON cycle 20 with start held through reset
        @(negedge clk);
        launch(32'hDEADBEEF, 32'd3, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        #1;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall2", 64'(stall_o), 64'd0);
        void'(sb_q.pop_back());
        rst = 1'b0;
        launch(32'd4000000000, 32'd12345, 1'b0);
        wait_ready(st);
        check("post_rst_stall_cycles", 64'(st), 64'd33);
        release_end(0, model(32'd4000000000, 32'd12345, 1'b0));

        run_div(32'd1000, 32'd3, 1'b0, 5, got);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, got);
        run_div(32'd7, 32'd9, 1'b0, 0, got);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst  input  1  reset; synchronous, active-high.
REQ-003: start_i  input  1  EX stage requests a divide; held high until the result is consumed.
REQ-004: annul_i  input  1  abort the divide in progress (pipeline flush).
REQ-005: signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at accept.
REQ-006: opdata1_i  input  32  dividend; sampled at accept.
REQ-007: opdata2_i  input  32  divisor; sampled at accept.
REQ-008: result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009: ready_o  output  1  result_o valid.
REQ-010: stall_o  output  1  combinational pipeline stall request to the stall controller.

Function
REQ-011: SHALL implement four states: IDLE, BYZERO, ON, END.
REQ-012: IDLE, start_i=1, annul_i=0 is "accept": operands latched; next state BYZERO if opdata2_i==0, else ON with iteration counter cleared to 0.
REQ-013: IDLE with start_i=0 or annul_i=1 SHALL remain IDLE; no operand latch.
REQ-014: BYZERO SHALL last exactly one cycle, then enter END with result 64'h0.
REQ-015: ON SHALL perform one restoring trial subtraction per cycle (33-bit partial remainder minus {1'b0,divisor}; shift in quotient bit 1 if non-negative, else 0); counter increments 0..31.
REQ-016: At the edge ending the 32nd ON cycle, the final quotient/remainder (with sign correction) SHALL be registered into result_o and the state SHALL become END; ready_o therefore first rises 33 edges after the accept edge.
REQ-017: In ON or BYZERO, annul_i=1 or start_i=0 SHALL return to IDLE at the next edge; ready_o stays 0 and result_o stays 0.
REQ-018: END SHALL hold ready_o=1 and result_o stable while start_i=1; start_i=0 moves to IDLE at the next edge; annul_i in END also moves to IDLE.
REQ-019: result_o SHALL be 64'h0 and ready_o 0 in every state other than END.
REQ-020: stall_o = 1 in BYZERO and ON, and in IDLE when accept conditions hold; 0 in END and otherwise.
REQ-021: Signed mode: negative operands converted to magnitude at accept; quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-022: 32'h80000000 / 32'hFFFFFFFF signed SHALL yield quotient 32'h80000000, remainder 0 (two's-complement wrap, no trap).
REQ-023: No new accept SHALL occur before the state returns to IDLE.

Reset
REQ-024: rst=1 at a clock edge SHALL force IDLE, counter 0, internal operand/partial registers 0, result_o 64'h0, ready_o 0, regardless of state (including mid-ON).
REQ-025: stall_o SHALL be 0 while rst=1.

Configuration
REQ-026: Macro DIV_SIGNED_EN defined: signed_div_i honoured per REQ-021/022.
REQ-027: DIV_SIGNED_EN undefined: signed_div_i ignored, all divides unsigned, sign-correction logic absent; timing unchanged.

Verification
REQ-028: unsigned 100/7, start_i held -> ready_o rises 33 edges after accept, result_o=64'h00000002_0000000E, stall_o high for the accept cycle plus 32 ON cycles.
REQ-029: signed -7/2 (32'hFFFFFFF9/2) with DIV_SIGNED_EN -> result_o=64'hFFFFFFFF_FFFFFFFD; without the macro -> 64'h00000001_7FFFFFFC.
REQ-030: 5/0 -> BYZERO one cycle, ready_o rises 2 edges after accept, result_o=64'h0.
REQ-031: annul_i pulsed during ON cycle 10 -> IDLE next edge, ready_o never rises; subsequent 0xFFFFFFFF/1 unsigned -> 64'h00000000_FFFFFFFF.
REQ-032: rst asserted during ON cycle 20 -> next edge IDLE, all outputs 0; start_i held through reset -> new accept on first edge after rst drops.
REQ-033: start_i held 5 cycles in END -> result_o/ready_o stable 5 cycles; start_i low -> ready_o 0 after next edge.
